// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST sequencer with in-line read checking.
//
// Runs the six March C- elements against a single-port synchronous memory,
// issuing one op per clock. Write data is presented one cycle ahead of its
// write command. Read data returns two cycles after the command, and each
// read is checked against its expected background three edges after it
// was issued.
//
// Ports:
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   start           one-cycle request to begin a test (ignored while busy)
//   mem_write_read  1 = write, 0 = read (registered)
//   mem_address     memory address (registered)
//   mem_wdata       data of the op issued on the next edge
//   mem_rdata       memory read data
//   busy / done     test in progress / test complete (done held until restart)
//   fail            sticky mismatch flag
//   fail_count      saturating count of mismatching reads
//   fail_addr       address of the first mismatch
//   fail_data       read data of the first mismatch
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_WORDS  = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam int unsigned ELEM_WIDTH = 3;
  localparam logic [ELEM_WIDTH-1:0] ELEM_LAST = 3'd5;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] BG_ZERO   = '0;
  localparam logic [DATA_WIDTH-1:0] BG_ONE    = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Elements 1..4 are read-then-write pairs on one address.
  function automatic logic is_pair(input logic [ELEM_WIDTH-1:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  // Elements 3 and 4 walk the address space downwards.
  function automatic logic is_desc(input logic [ELEM_WIDTH-1:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic op_is_write(input logic [ELEM_WIDTH-1:0] e, input logic ph);
    logic w;
    case (e)
      3'd0:    w = 1'b1;
      3'd5:    w = 1'b0;
      default: w = ph;
    endcase
    return w;
  endfunction

  // Background for the op: written value for writes, expected value for reads.
  function automatic logic [DATA_WIDTH-1:0] op_data(input logic [ELEM_WIDTH-1:0] e,
                                                    input logic ph);
    logic [DATA_WIDTH-1:0] d;
    case (e)
      3'd1, 3'd3: d = ph ? BG_ONE : BG_ZERO;
      3'd2, 3'd4: d = ph ? BG_ZERO : BG_ONE;
      default:    d = BG_ZERO;
    endcase
    return d;
  endfunction

  state_t                  state_q;
  // Pointer to the op that will be issued on the next edge.
  logic [ELEM_WIDTH-1:0]   elem_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    ph_q;
  logic [ELEM_WIDTH-1:0]   elem_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    ph_d;
  logic [ELEM_WIDTH-1:0]   elem_inc_c;
  logic                    elem_end_c;

  // Read-check pipeline: stage 2 lines up with the returning read data.
  logic [2:0]              rd_vld_q;
  logic [DATA_WIDTH-1:0]   rd_exp_q  [3];
  logic [ADDR_WIDTH-1:0]   rd_addr_q [3];

  logic                    cur_we_c;
  logic [DATA_WIDTH-1:0]   cur_data_c;
  logic [DATA_WIDTH-1:0]   nxt_data_c;
  logic                    last_op_c;
  logic                    issue_c;
  logic                    mismatch_c;

  assign cur_we_c   = op_is_write(elem_q, ph_q);
  assign cur_data_c = op_data(elem_q, ph_q);
  assign nxt_data_c = op_data(elem_d, ph_d);
  assign last_op_c  = (elem_q == ELEM_LAST) && (addr_q == ADDR_LAST);
  assign issue_c    = (state_q == ST_RUN) ||
                      (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start);
  assign mismatch_c = rd_vld_q[2] && (mem_rdata != rd_exp_q[2]);

  // Successor of the op pointer; the address only wraps at element ends.
  always_comb begin
    elem_d     = elem_q;
    addr_d     = addr_q;
    ph_d       = 1'b0;
    elem_inc_c = elem_q + 3'd1;
    elem_end_c = is_desc(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
    if (is_pair(elem_q) && !ph_q) begin
      ph_d = 1'b1;
    end else if (elem_end_c) begin
      elem_d = elem_inc_c;
      addr_d = is_desc(elem_inc_c) ? ADDR_LAST : '0;
    end else if (is_desc(elem_q)) begin
      addr_d = addr_q - ADDR_WIDTH'(1);
    end else begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  // Sequencer, memory-side outputs, read checking and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      elem_q         <= '0;
      addr_q         <= '0;
      ph_q           <= 1'b0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_count     <= '0;
      fail_addr      <= '0;
      fail_data      <= '0;
      rd_vld_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        rd_exp_q[i]  <= '0;
        rd_addr_q[i] <= '0;
      end
    end else begin
      rd_vld_q     <= {rd_vld_q[1:0], 1'b0};
      rd_exp_q[1]  <= rd_exp_q[0];
      rd_exp_q[2]  <= rd_exp_q[1];
      rd_addr_q[1] <= rd_addr_q[0];
      rd_addr_q[2] <= rd_addr_q[1];

      if (mismatch_c) begin
        fail <= 1'b1;
        if (fail_count != '1) begin
          fail_count <= fail_count + CNT_WIDTH'(1);
        end
        if (!fail) begin
          fail_addr <= rd_addr_q[2];
          fail_data <= mem_rdata;
        end
      end

      if (issue_c) begin
        mem_write_read <= cur_we_c;
        mem_address    <= addr_q;
        mem_wdata      <= nxt_data_c;
        rd_vld_q[0]    <= ~cur_we_c;
        rd_exp_q[0]    <= cur_data_c;
        rd_addr_q[0]   <= addr_q;
        elem_q         <= elem_d;
        addr_q         <= addr_d;
        ph_q           <= ph_d;
      end else begin
        mem_write_read <= 1'b0;
        mem_address    <= '0;
        mem_wdata      <= '0;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Pipeline is empty here, so clearing cannot race a compare.
          if (start) begin
            state_q    <= ST_RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
          end
        end
        ST_RUN: begin
          if (last_op_c) begin
            state_q   <= ST_DRAIN;
            mem_wdata <= '0;
            elem_q    <= '0;
            addr_q    <= '0;
            ph_q      <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Only the final read remains in stage 2: its compare is this edge.
          if (rd_vld_q[1:0] == 2'b00) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural op-list model plus a memory model
// with optional stuck-at fault; a second instance sees a constant-0xAA memory.
module tb_mbist_march_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int NW   = 16;
  localparam int NOPS = 10 * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic          we1, busy1, done1, fail1;
  logic [AW-1:0] addr1, faddr1;
  logic [DW-1:0] wdata1, rdata1, fdata1;
  logic [7:0]    cnt1;

  logic          we2, busy2, done2, fail2;
  logic [AW-1:0] addr2, faddr2;
  logic [DW-1:0] wdata2, fdata2;
  logic [DW-1:0] rdata2;
  logic [1:0]    cnt2;
  assign rdata2 = 8'hAA;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_write_read(we1), .mem_address(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .busy(busy1), .done(done1), .fail(fail1), .fail_count(cnt1),
    .fail_addr(faddr1), .fail_data(fdata1)
  );

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .mem_write_read(we2), .mem_address(addr2), .mem_wdata(wdata2), .mem_rdata(rdata2),
    .busy(busy2), .done(done2), .fail(fail2), .fail_count(cnt2),
    .fail_addr(faddr2), .fail_data(fdata2)
  );

  // Memory: write data sampled one cycle before the write command, read data
  // returned two cycles after the read command. Mode 1: bit 3 of word 5 stuck-at-1.
  int            fault_mode = 0;
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] wd_q, rd1;

  function automatic logic [DW-1:0] fault_read(input int mode, input int a, input logic [DW-1:0] v);
    return (mode == 1 && a == 5) ? (v | 8'h08) : v;
  endfunction

  always @(posedge clk) begin
    wd_q <= wdata1;
    if (we1) mem[addr1] <= wd_q;
    rd1    <= fault_read(fault_mode, int'(addr1), mem[addr1]);
    rdata1 <= rd1;
  end

  // Reference op list for March C-.
  bit            op_we   [NOPS];
  logic [AW-1:0] op_addr [NOPS];
  logic [DW-1:0] op_data [NOPS];
  int            nops_built = 0;

  task automatic add_op(input bit w, input int a, input bit one);
    op_we[nops_built]   = w;
    op_addr[nops_built] = AW'(a);
    op_data[nops_built] = one ? 8'hFF : 8'h00;
    nops_built++;
  endtask

  task automatic build_ops();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < NW; i++) begin
        int a;
        a = (e == 3 || e == 4) ? (NW - 1 - i) : i;
        case (e)
          0: add_op(1'b1, a, 1'b0);
          1: begin add_op(1'b0, a, 1'b0); add_op(1'b1, a, 1'b1); end
          2: begin add_op(1'b0, a, 1'b1); add_op(1'b1, a, 1'b0); end
          3: begin add_op(1'b0, a, 1'b0); add_op(1'b1, a, 1'b1); end
          4: begin add_op(1'b0, a, 1'b1); add_op(1'b1, a, 1'b0); end
          default: add_op(1'b0, a, 1'b0);
        endcase
      end
    end
  endtask

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: cycles since the accepted start edge (-1 = reset, no result yet).
  int m_cyc  = -1;
  int m_mode = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) m_cyc = -1;
    else if ((m_cyc < 0 || m_cyc >= NOPS + 2) && start) begin
      m_cyc  = 0;
      m_mode = fault_mode;
    end else if (m_cyc >= 0) m_cyc++;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    int c, cnt, fa, ex_busy;
    logic [DW-1:0] fd, ret, ex_wd;
    c = m_cyc;
    if (c < 0) begin
      chk("idle_we", 64'(we1), 64'd0);
      chk("idle_addr", 64'(addr1), 64'd0);
      chk("idle_wdata", 64'(wdata1), 64'd0);
      chk("idle_busy", 64'(busy1), 64'd0);
      chk("idle_done", 64'(done1), 64'd0);
      chk("idle_fail", 64'(fail1), 64'd0);
      chk("idle_cnt", 64'(cnt1), 64'd0);
      chk("idle_faddr", 64'(faddr1), 64'd0);
      chk("idle_fdata", 64'(fdata1), 64'd0);
    end else begin
      chk("we", 64'(we1), 64'((c < NOPS) ? op_we[c] : 1'b0));
      if (c < NOPS) chk("addr", 64'(addr1), 64'(op_addr[c]));
      ex_wd = (c + 1 < NOPS) ? op_data[c+1] : 8'h00;
      chk("wdata", 64'(wdata1), 64'(ex_wd));
      ex_busy = (c < NOPS + 2) ? 1 : 0;
      chk("busy", 64'(busy1), 64'(ex_busy));
      chk("done", 64'(done1), 64'(1 - ex_busy));
      cnt = 0; fa = 0; fd = '0;
      for (int r = 0; r < NOPS && r + 3 <= c; r++) begin
        if (!op_we[r]) begin
          ret = fault_read(m_mode, int'(op_addr[r]), op_data[r]);
          if (ret != op_data[r]) begin
            if (cnt == 0) begin fa = int'(op_addr[r]); fd = ret; end
            cnt++;
          end
        end
      end
      chk("fail", 64'(fail1), 64'((cnt > 0) ? 1 : 0));
      chk("fail_count", 64'(cnt1), 64'((cnt > 255) ? 255 : cnt));
      chk("fail_addr", 64'(faddr1), 64'(fa));
      chk("fail_data", 64'(fdata1), 64'(fd));
    end
  end

  int edge_n = 0;

  task automatic goto_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // Called #1 after an edge; the next edge becomes edge 0.
  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    edge_n = 0;
    #1;
    start = 1'b0;
  endtask

  initial begin
    build_ops();
    chk("op_list_len", 64'(nops_built), 64'd160);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_we", 64'(we1), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean run with ignored mid-test starts.
    launch();
    chk("e0_first_we", 64'(we1), 64'd1);
    goto_edge(14); chk("lead_e0_last_wdata", 64'(wdata1), 64'h00);
    goto_edge(15); chk("e0_last_we", 64'(we1), 64'd1);
                   chk("e0_last_addr", 64'(addr1), 64'd15);
    goto_edge(16); chk("lead_e1_w1_wdata", 64'(wdata1), 64'hFF);
                   chk("e1_r0_we", 64'(we1), 64'd0);
    goto_edge(17); chk("e1_w1_we", 64'(we1), 64'd1);
                   chk("e1_w1_addr", 64'(addr1), 64'd0);
                   chk("sat_e1_w1_we", 64'(we2), 64'd1);
                   chk("sat_e1_w1_addr", 64'(addr2), 64'd0);
    goto_edge(39); start = 1'b1;
    goto_edge(40); start = 1'b0;
    chk("ignored_start_busy", 64'(busy1), 64'd1);
    goto_edge(99); start = 1'b1;
    goto_edge(100); start = 1'b0;
    goto_edge(161); chk("busy_161", 64'(busy1), 64'd1);
                    chk("done_161", 64'(done1), 64'd0);
    goto_edge(162); chk("done_162", 64'(done1), 64'd1);
                    chk("busy_162", 64'(busy1), 64'd0);
                    chk("clean_fail", 64'(fail1), 64'd0);
                    chk("clean_cnt", 64'(cnt1), 64'd0);
                    chk("sat_fail", 64'(fail2), 64'd1);
                    chk("sat_cnt", 64'(cnt2), 64'd3);
                    chk("sat_faddr", 64'(faddr2), 64'd0);
                    chk("sat_fdata", 64'(fdata2), 64'hAA);
                    chk("sat_done", 64'(done2), 64'd1);
                    chk("sat_busy", 64'(busy2), 64'd0);
                    chk("sat_we", 64'(we2), 64'd0);
                    chk("sat_wdata", 64'(wdata2), 64'h00);

    // Stuck-at-1 on bit 3 of word 5.
    goto_edge(170);
    fault_mode = 1;
    launch();
    goto_edge(165);
    chk("stuck_fail", 64'(fail1), 64'd1);
    chk("stuck_faddr", 64'(faddr1), 64'd5);
    chk("stuck_fdata", 64'(fdata1), 64'h08);
    chk("stuck_cnt", 64'(cnt1), 64'd3);
    chk("stuck_done", 64'(done1), 64'd1);

    // Relaunch from DONE clears the result; then abort with reset.
    goto_edge(170);
    fault_mode = 0;
    launch();
    chk("relaunch_fail", 64'(fail1), 64'd0);
    chk("relaunch_cnt", 64'(cnt1), 64'd0);
    chk("relaunch_done", 64'(done1), 64'd0);
    chk("relaunch_busy", 64'(busy1), 64'd1);
    goto_edge(50);
    #1 rst = 1'b1;
    #1;
    chk("abort_we", 64'(we1), 64'd0);
    chk("abort_addr", 64'(addr1), 64'd0);
    chk("abort_wdata", 64'(wdata1), 64'd0);
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Clean run after abort.
    launch();
    goto_edge(162);
    chk("post_abort_done", 64'(done1), 64'd1);
    chk("post_abort_fail", 64'(fail1), 64'd0);
    chk("post_abort_cnt", 64'(cnt1), 64'd0);
    goto_edge(168);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- MBIST sequencer that runs a March C- test on a single-port synchronous memory and checks every read against the expected background.
- Drives the memory-side write_read / address / wdata interface directly and honours its timing: write data leads the write command by one cycle, read data returns two cycles after the command.
- Sits between the BIST start/status logic and the memory under test, including the fault-injected memory models.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- NUM_WORDS, 16, number of words tested, addresses 0..NUM_WORDS-1; must be ≤ 2^ADDR_WIDTH and ≥ 2.
- CNT_WIDTH, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a test.
- mem_write_read  out  1  1 = write, 0 = read; registered.
- mem_address  out  ADDR_WIDTH  memory address; registered.
- mem_wdata  out  DATA_WIDTH  write data, presented one cycle ahead of its write command.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  test in progress.
- done  out  1  test complete; held until the next accepted start.
- fail  out  1  sticky; at least one mismatch seen.
- fail_count  out  CNT_WIDTH  number of mismatching reads, saturating at all-ones.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_data  out  DATA_WIDTH  read data of the first mismatch.

Behaviour:
- Reset, asynchronous, applies immediately, including mid-test:
  - state = IDLE; all outputs 0.
  - mem_write_read = 0 (read), so an aborted test never writes.
- FSM:
  - IDLE: start=1 → RUN.
  - RUN: after the last op is issued → DRAIN.
  - DRAIN: when the last compare completes → DONE.
  - DONE: start=1 → RUN.
  - start is ignored in RUN and DRAIN. An accepted start clears done, fail, fail_count, fail_addr and fail_data.
- March C- elements, one op per clock with no bubbles:
  - E0 ⇑ (w0).
  - E1 ⇑ (r0, w1).
  - E2 ⇑ (r1, w0).
  - E3 ⇓ (r0, w1).
  - E4 ⇓ (r1, w0).
  - E5 ⇑ (r0).
  - "0" means all-zeros and "1" means all-ones, DATA_WIDTH wide.
  - Multi-op elements issue both ops on the same address on consecutive cycles, then step the address.
  - ⇑ runs 0..NUM_WORDS-1. ⇓ runs NUM_WORDS-1..0.
  - Total 10·NUM_WORDS op cycles.
- Issue timing:
  - The start-sample edge is edge 0; the first op is driven from edge 0.
  - The op for cycle k is driven on edge k, for k = 0..10N-1.
  - busy = 1 from edge 0 until done rises.
- Write-data lead:
  - On every edge, mem_wdata = data of the op that will be driven on the next edge.
  - If the next op is a read, drive its expected background.
  - In IDLE and DONE, mem_wdata = 0, so E0's first write is correct.
- Read check:
  - A read driven on edge k is compared at edge k+3 against a 3-stage pipeline of {valid, expected, address}.
  - On mismatch: fail ← 1; fail_count increments unless saturated.
  - On the first mismatch only: capture fail_addr and fail_data.
  - Mismatches in the same cycle as each other cannot occur, since there is at most one compare per cycle.
- Completion: done rises and busy falls on edge 10N+2, the compare edge of the final E5 read.
- Counters: the address counter wraps only at element boundaries; no op is ever issued outside 0..NUM_WORDS-1.

Test Plan:
- Fault-free memory, N=16, start pulse at edge 0 → 160 ops in order; done=1 and busy=0 from edge 162; fail=0, fail_count=0.
- Memory with bit 3 of address 5 stuck-at-1, DATA_WIDTH=8 → fail=1, fail_addr=5, fail_data=8'h08 (from the E1 read), fail_count=3 (E1, E3 and E5 reads).
- Check the write-data lead: at edge 15, mem_write_read=1 and mem_address=15 (last E0 write), and at edge 14, mem_wdata=8'h00. At edge 17, mem_write_read=1 and mem_address=0 (first E1 write), and at edge 16, mem_wdata=8'hFF.
- Assert rst at edge 50 → all outputs 0 immediately, no further writes; a new start runs a full clean test to done with no residual fail.
- Pulse start at edge 40 and again at edge 100 → ignored. In DONE, start re-launches and clears a previous fail=1 / fail_count=3.
- CNT_WIDTH=2 with a memory returning 8'hAA always → fail_count saturates at 3; fail_addr=0, fail_data=8'hAA.
